// File: rtl/fifo_ser_pkg.sv
// fifo_ser_pkg: shared types and sizing helpers for the FIFO dequeue serializer
package fifo_ser_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } ser_state_e;

    function automatic int ser_ratio(input int w, input int bw);
        return (bw > 0) ? w / bw : 0;
    endfunction

    // Keep the beat counter at least one bit wide even for degenerate ratios.
    function automatic int ser_idx_w(input int ratio);
        return (ratio > 1) ? $clog2(ratio) : 1;
    endfunction

endpackage

// File: rtl/fifo_deq_serializer.sv
// fifo_deq_serializer: pulls wide words from an upstream FIFO and emits them as narrow beats
//   CLK        in   clock, rising edge
//   RST        in   asynchronous active-high reset
//   CLR        in   synchronous clear, drops any held word
//   IN_D       in   upstream word
//   IN_EMPTY_N in   upstream holds a word
//   IN_DEQ     out  upstream dequeue strobe
//   OUT_D      out  current beat
//   OUT_LAST   out  current beat ends its word
//   OUT_ENQ    out  downstream enqueue strobe
//   OUT_FULL_N in   downstream can accept a beat
//   BUSY       out  a word is held
module fifo_deq_serializer
    import fifo_ser_pkg::*;
#(
    parameter int width     = 32,
    parameter int beatWidth = 8,
    parameter bit lsbFirst  = 1'b1
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 CLR,
    input  logic [width-1:0]     IN_D,
    input  logic                 IN_EMPTY_N,
    output logic                 IN_DEQ,
    output logic [beatWidth-1:0] OUT_D,
    output logic                 OUT_LAST,
    output logic                 OUT_ENQ,
    input  logic                 OUT_FULL_N,
    output logic                 BUSY
);

    localparam int RATIO = ser_ratio(width, beatWidth);
    localparam int IW    = ser_idx_w(RATIO);
    localparam logic [IW-1:0] IDX_LAST = IW'(RATIO - 1);

    if ((width % beatWidth) != 0 || RATIO < 2) begin : g_bad_params
        $error("fifo_deq_serializer: width must be a multiple of beatWidth with ratio >= 2");
    end

    ser_state_e       state, state_nx;
    logic [width-1:0] sr, sr_nx, sr_shifted;
    logic [IW-1:0]    idx, idx_nx;
    logic             last, in_shift;

    assign in_shift   = (state == SHIFT);
    assign last       = (idx == IDX_LAST);
    // The consumed beat leaves from the emitting end; zeros fill in behind it.
    assign sr_shifted = lsbFirst ? (sr >> beatWidth) : (sr << beatWidth);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
            sr    <= '0;
            idx   <= '0;
        end else begin
            state <= state_nx;
            sr    <= sr_nx;
            idx   <= idx_nx;
        end
    end

    // IN_DEQ in SHIFT implies the final beat is leaving this cycle, so a
    // dequeue always means (re)load regardless of the current state.
    always_comb begin
        state_nx = state;
        sr_nx    = sr;
        idx_nx   = idx;
        if (CLR) begin
            state_nx = IDLE;
            idx_nx   = '0;
        end else if (IN_DEQ) begin
            state_nx = SHIFT;
            sr_nx    = IN_D;
            idx_nx   = '0;
        end else if (OUT_ENQ) begin
            state_nx = last ? IDLE : SHIFT;
            sr_nx    = last ? sr : sr_shifted;
            idx_nx   = last ? '0 : idx + IW'(1);
        end
    end

    // IN_DEQ looks at OUT_FULL_N so a new word lands exactly as the last beat
    // leaves, keeping the beat stream gap-free across word boundaries.
    always_comb begin
        OUT_ENQ  = in_shift & OUT_FULL_N & ~CLR;
        IN_DEQ   = ~RST & IN_EMPTY_N & ~CLR & (~in_shift | (last & OUT_FULL_N));
        OUT_D    = lsbFirst ? sr[beatWidth-1:0] : sr[width-1 -: beatWidth];
        OUT_LAST = in_shift & last;
        BUSY     = in_shift;
    end

`ifndef SYNTHESIS
    a_enq_needs_room: assert property (@(posedge CLK) disable iff (RST) !(OUT_ENQ && !OUT_FULL_N))
        else $warning("fifo_deq_serializer: OUT_ENQ asserted while OUT_FULL_N is low");
`endif

endmodule

// File: tb/tb_fifo_deq_serializer.sv
// tb_fifo_deq_serializer: randomized and directed checks of the serializer against a beat-queue model
module tb_fifo_deq_serializer;

    logic        CLK = 1'b0;
    logic        RST;
    logic        CLR;
    logic        IN_EMPTY_N;
    logic        OUT_FULL_N;
    logic [31:0] IN_D;
    logic        deq_l, deq_m, enq_l, enq_m, last_l, last_m, busy_l, busy_m;
    logic [7:0]  od_l, od_m;

    logic [31:0] mem [1024];
    int          wr_ptr = 0;
    int          rd_ptr = 0;

    typedef struct {
        int         cyc;
        logic [7:0] dl;
        logic [7:0] dm;
        logic       ll;
    } beat_t;

    beat_t      log_q [$];
    int         deq_q [$];
    logic [7:0] exp_l [$];
    logic [7:0] exp_m [$];
    int         cyc    = 0;
    int         checks = 0;
    int         fails  = 0;

    always #5 CLK = ~CLK;

    assign IN_D       = mem[rd_ptr[9:0]];
    assign IN_EMPTY_N = (wr_ptr != rd_ptr);

    always @(posedge CLK) if (deq_l) rd_ptr <= rd_ptr + 1;

    fifo_deq_serializer #(.width(32), .beatWidth(8), .lsbFirst(1'b1)) u_lsb (
        .CLK(CLK), .RST(RST), .CLR(CLR), .IN_D(IN_D), .IN_EMPTY_N(IN_EMPTY_N),
        .IN_DEQ(deq_l), .OUT_D(od_l), .OUT_LAST(last_l), .OUT_ENQ(enq_l),
        .OUT_FULL_N(OUT_FULL_N), .BUSY(busy_l)
    );

    fifo_deq_serializer #(.width(32), .beatWidth(8), .lsbFirst(1'b0)) u_msb (
        .CLK(CLK), .RST(RST), .CLR(CLR), .IN_D(IN_D), .IN_EMPTY_N(IN_EMPTY_N),
        .IN_DEQ(deq_m), .OUT_D(od_m), .OUT_LAST(last_m), .OUT_ENQ(enq_m),
        .OUT_FULL_N(OUT_FULL_N), .BUSY(busy_m)
    );

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%h expected=%h (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    // Model: the remaining beats of the held word, one queue per beat order.
    always @(negedge CLK) begin
        int   n;
        logic e_enq, e_deq;
        cyc++;
        if (RST) begin
            chk("rst_enq", {enq_l, enq_m}, 2'b00);
            chk("rst_deq", {deq_l, deq_m}, 2'b00);
            chk("rst_busy", {busy_l, busy_m}, 2'b00);
            chk("rst_last", {last_l, last_m}, 2'b00);
            chk("rst_od", {od_l, od_m}, 16'h0);
            exp_l.delete();
            exp_m.delete();
        end else begin
            n     = exp_l.size();
            e_enq = (n > 0) && OUT_FULL_N && !CLR;
            e_deq = IN_EMPTY_N && !CLR && (n == 0 || (n == 1 && OUT_FULL_N));
            chk("enq_l", enq_l, e_enq);
            chk("enq_m", enq_m, e_enq);
            chk("deq_l", deq_l, e_deq);
            chk("deq_m", deq_m, e_deq);
            chk("busy", {busy_l, busy_m}, {2{n > 0}});
            chk("last", {last_l, last_m}, {2{n == 1}});
            if (n > 0) begin
                chk("od_l", od_l, exp_l[0]);
                chk("od_m", od_m, exp_m[0]);
            end
            if (enq_l) log_q.push_back('{cyc, od_l, od_m, last_l});
            if (deq_l) deq_q.push_back(cyc);
            if (CLR) begin
                exp_l.delete();
                exp_m.delete();
            end else begin
                if (e_enq) begin
                    void'(exp_l.pop_front());
                    void'(exp_m.pop_front());
                end
                if (e_deq)
                    for (int i = 0; i < 4; i++) begin
                        exp_l.push_back(IN_D[8*i +: 8]);
                        exp_m.push_back(IN_D[8*(3-i) +: 8]);
                    end
            end
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic push_word(input logic [31:0] w);
        mem[wr_ptr[9:0]] = w;
        wr_ptr++;
    endtask

    task automatic wait_beats(input int n);
        for (int k = 0; k < 60 && log_q.size() < n; k++) step();
        chk("wait_beats", log_q.size(), n);
    endtask

    task automatic expect_lsb(input logic [31:0] w, input int base);
        for (int i = 0; i < 4; i++) begin
            chk("beat_lsb", log_q[base+i].dl, w[8*i +: 8]);
            chk("beat_last", log_q[base+i].ll, i == 3);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] e [4];
        RST        = 1'b1;
        CLR        = 1'b0;
        OUT_FULL_N = 1'b1;
        push_word(32'h44332211);
        step(2);
        chk("reset_deq", deq_l, 1'b0);
        chk("reset_busy", busy_l, 1'b0);
        chk("reset_od", od_l, 8'h00);
        RST = 1'b0;
        wait_beats(4);
        step(4);
        chk("a_count", log_q.size(), 4);
        e = '{8'h11, 8'h22, 8'h33, 8'h44};
        for (int i = 0; i < 4; i++) begin
            chk("a_lsb", log_q[i].dl, e[i]);
            chk("a_msb", log_q[i].dm, e[3-i]);
            chk("a_last", log_q[i].ll, i == 3);
            chk("a_cyc", log_q[i].cyc, log_q[0].cyc + i);
        end
        chk("a_deq_once", deq_q.size(), 1);

        log_q.delete();
        deq_q.delete();
        push_word(32'h44332211);
        push_word(32'h88776655);
        wait_beats(8);
        step(3);
        chk("b_count", log_q.size(), 8);
        expect_lsb(32'h44332211, 0);
        expect_lsb(32'h88776655, 4);
        for (int i = 1; i < 8; i++) chk("b_nogap", log_q[i].cyc, log_q[0].cyc + i);
        chk("b_deq_count", deq_q.size(), 2);
        if (deq_q.size() == 2) chk("b_deq2_at_44", deq_q[1], log_q[3].cyc);

        log_q.delete();
        push_word(32'h44332211);
        wait_beats(1);
        OUT_FULL_N = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            chk("c_hold_od", od_l, 8'h22);
            chk("c_hold_enq", enq_l, 1'b0);
        end
        step();
        OUT_FULL_N = 1'b1;
        wait_beats(4);
        step(2);
        chk("c_count", log_q.size(), 4);
        expect_lsb(32'h44332211, 0);
        chk("c_resume", log_q[2].cyc, log_q[1].cyc + 1);

        log_q.delete();
        push_word(32'hA1B2C3D4);
        wait_beats(4);
        step(2);
        e = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        for (int i = 0; i < 4; i++) chk("d_msb", log_q[i].dm, e[i]);

        log_q.delete();
        push_word(32'h44332211);
        wait_beats(2);
        CLR = 1'b1;
        step();
        CLR = 1'b0;
        @(negedge CLK);
        chk("e_busy_after_clr", busy_l, 1'b0);
        step(4);
        chk("e_no_more_beats", log_q.size(), 2);
        log_q.delete();
        push_word(32'hDEADBEEF);
        wait_beats(4);
        step(2);
        e = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
        for (int i = 0; i < 4; i++) chk("e_after_clr", log_q[i].dl, e[i]);

        log_q.delete();
        push_word(32'h44332211);
        wait_beats(1);
        #2;
        RST = 1'b1;
        #1;
        chk("f_async_od", {od_l, od_m}, 16'h0);
        chk("f_async_enq", {enq_l, enq_m}, 2'b00);
        chk("f_async_busy", {busy_l, busy_m}, 2'b00);
        chk("f_async_last", {last_l, last_m}, 2'b00);
        chk("f_async_deq", deq_l, 1'b0);
        step(2);
        RST = 1'b0;
        @(negedge CLK);
        chk("f_post_deq", deq_l, 1'b0);
        chk("f_post_busy", busy_l, 1'b0);

        for (int k = 0; k < 800; k++) begin
            step();
            if ($urandom_range(0, 3) == 0 && (wr_ptr - rd_ptr) < 6) push_word($urandom);
            OUT_FULL_N = ($urandom_range(0, 3) != 0);
            CLR        = ($urandom_range(0, 49) == 0);
        end
        step();
        CLR        = 1'b0;
        OUT_FULL_N = 1'b1;
        for (int k = 0; k < 200 && (wr_ptr != rd_ptr || busy_l); k++) step();
        chk("drained", {IN_EMPTY_N, busy_l}, 2'b00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
